// File: rtl/motors_step_ctrl_pkg.sv
// Shared types and default constants for the two-axis step pulse generator.
package motors_step_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PULSE_HI,
    PULSE_LO,
    DONE
  } state_t;

  localparam int DEF_STEP_WIDTH = 16;
  localparam int DEF_PULSE_HIGH = 2;
  localparam int DEF_PULSE_LOW  = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/motors_step_ctrl_pulse_timer.sv
// Dwell timer for the step pulse phases: counts clk_en ticks down to zero.
module pulse_timer
  import motors_step_ctrl_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clk_en) begin
      if (load) begin
        count <= load_val;
      end else if (count != '0) begin
        count <= count - WIDTH'(1);
      end
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/motors_step_ctrl.sv
// Two-axis Bresenham step/direction pulse generator.
// Optional build macro MOTORS_STEP_CTRL_ABORT_EN adds an abort input that ends a move early.
module motors_step_ctrl
  import motors_step_ctrl_pkg::*;
#(
  parameter int STEP_WIDTH = DEF_STEP_WIDTH,
  parameter int PULSE_HIGH = DEF_PULSE_HIGH,
  parameter int PULSE_LOW  = DEF_PULSE_LOW
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic                         trigger,
`ifdef MOTORS_STEP_CTRL_ABORT_EN
  input  logic                         abort,
`endif
  input  logic signed [STEP_WIDTH-1:0] x_steps,
  input  logic signed [STEP_WIDTH-1:0] y_steps,
  output logic                         step_x,
  output logic                         dir_x,
  output logic                         step_y,
  output logic                         dir_y,
  output logic                         done,
  output logic                         rdy
);

  localparam int MW = STEP_WIDTH + 1;
  localparam int EW = STEP_WIDTH + 2;
  localparam int TW = $clog2(max_int(PULSE_HIGH, PULSE_LOW) + 1);

  state_t          state, state_nxt;
  logic [MW-1:0]   major, minor, step_cnt;
  logic [EW-1:0]   err;
  logic            x_major, minor_hit;
  logic [MW-1:0]   mag_x, mag_y, load_major, load_minor;
  logic            load_x_major;
  logic            step_on, timer_load, timer_expired;
  logic [TW-1:0]   timer_val;

  // Magnitude in one extra bit so the most negative count is representable.
  function automatic logic [MW-1:0] mag(input logic [STEP_WIDTH-1:0] v);
    logic [MW-1:0] w;
    w = {v[STEP_WIDTH-1], v};
    return v[STEP_WIDTH-1] ? (~w + MW'(1)) : w;
  endfunction

  // One Bresenham step: returns {minor axis steps, updated error}.
  function automatic logic [EW:0] bres(input logic [EW-1:0] e,
                                       input logic [MW-1:0] mn,
                                       input logic [MW-1:0] mj);
    logic [EW-1:0] s;
    s = e + EW'(mn);
    if (s >= EW'(mj)) return {1'b1, s - EW'(mj)};
    return {1'b0, s};
  endfunction

  assign mag_x        = mag(x_steps);
  assign mag_y        = mag(y_steps);
  assign load_x_major = (mag_x >= mag_y);
  assign load_major   = load_x_major ? mag_x : mag_y;
  assign load_minor   = load_x_major ? mag_y : mag_x;

  pulse_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rdy        = 1'b0;
    done       = 1'b0;
    step_on    = 1'b0;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state)
      IDLE: begin
        rdy  = 1'b1;
        done = !(trigger && clk_en);
        if (trigger) state_nxt = LOAD;
      end
      LOAD: begin
        if (load_major == '0) begin
          state_nxt = DONE;
        end else begin
          state_nxt  = PULSE_HI;
          timer_load = 1'b1;
          timer_val  = TW'(PULSE_HIGH - 1);
        end
      end
      PULSE_HI: begin
        step_on = 1'b1;
        if (timer_expired) begin
          state_nxt  = PULSE_LO;
          timer_load = 1'b1;
          timer_val  = TW'(PULSE_LOW - 1);
        end
      end
      PULSE_LO: begin
        if (timer_expired) begin
          if (step_cnt == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt  = PULSE_HI;
            timer_load = 1'b1;
            timer_val  = TW'(PULSE_HIGH - 1);
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef MOTORS_STEP_CTRL_ABORT_EN
    if (abort && clk_en && (state == PULSE_HI || state == PULSE_LO)) begin
      state_nxt  = DONE;
      timer_load = 1'b0;
      step_on    = 1'b0;
    end
`endif
  end

  assign step_x = step_on && (x_major || minor_hit);
  assign step_y = step_on && (!x_major || minor_hit);

  // Move parameters latch in LOAD; error advances on every entry to PULSE_HI.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      major     <= '0;
      minor     <= '0;
      step_cnt  <= '0;
      err       <= '0;
      x_major   <= 1'b1;
      minor_hit <= 1'b0;
    end else if (clk_en) begin
      if (state == LOAD) begin
        dir_x              <= !x_steps[STEP_WIDTH-1];
        dir_y              <= !y_steps[STEP_WIDTH-1];
        major              <= load_major;
        minor              <= load_minor;
        x_major            <= load_x_major;
        step_cnt           <= load_major;
        {minor_hit, err}   <= bres('0, load_minor, load_major);
      end else if (state == PULSE_LO && state_nxt == PULSE_HI) begin
        {minor_hit, err}   <= bres(err, minor, major);
      end
      if (state == PULSE_HI && state_nxt == PULSE_LO) begin
        step_cnt <= step_cnt - MW'(1);
      end
    end
  end

endmodule

// File: tb/tb_motors_step_ctrl.sv
// Scoreboard bench for motors_step_ctrl; a narrow step width keeps the most-negative move short.
module tb_motors_step_ctrl;

  localparam int SW = 8;
  localparam int PH = 2;
  localparam int PL = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_en = 1'b0;
  logic trigger = 1'b0;
  logic signed [SW-1:0] x_steps = '0;
  logic signed [SW-1:0] y_steps = '0;
  logic step_x, dir_x, step_y, dir_y, done, rdy;
`ifdef MOTORS_STEP_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif

  int n_checks = 0;
  int n_pass = 0;
  logic [3:0] pulse_q[$];
  int dur_q[$];
  bit en_rand = 1'b0;
  bit aborted = 1'b0;
  int cnt_x = 0;
  int cnt_y = 0;
  bit prev_on = 1'b0;
  bit prev_done = 1'b1;
  int hi_ticks = 0;
  int low_ticks = 0;

  motors_step_ctrl #(.STEP_WIDTH(SW), .PULSE_HIGH(PH), .PULSE_LOW(PL)) dut (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .trigger (trigger),
`ifdef MOTORS_STEP_CTRL_ABORT_EN
    .abort   (abort),
`endif
    .x_steps (x_steps),
    .y_steps (y_steps),
    .step_x  (step_x),
    .dir_x   (dir_x),
    .step_y  (step_y),
    .dir_y   (dir_y),
    .done    (done),
    .rdy     (rdy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  // Monitor: pops expected pulses and move lengths as the DUT presents them.
  always @(negedge clk) begin
    logic on;
    logic [3:0] exp_p;
    if (reset) begin
      on = step_x | step_y;
      if (on && !prev_on) begin
        cnt_x += int'(step_x);
        cnt_y += int'(step_y);
        hi_ticks = 0;
        if (pulse_q.size() == 0) begin
          chk("pulse_unexpected", 1, 0);
        end else begin
          exp_p = pulse_q.pop_front();
          chk("pulse_pattern", int'({step_x, step_y, dir_x, dir_y}), int'(exp_p));
        end
      end
      if (on && clk_en) hi_ticks++;
      if (!on && prev_on && !aborted) chk("pulse_width", hi_ticks, PH);
      if (!done && clk_en) low_ticks++;
      if (done && !prev_done) begin
        if (aborted) aborted = 1'b0;
        else if (dur_q.size() == 0) chk("move_unexpected", 1, 0);
        else chk("move_ticks", low_ticks, dur_q.pop_front());
        low_ticks = 0;
      end
      prev_on = on;
      prev_done = done;
    end
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
    clk_en = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // Reference: minor axis steps on pulse k when floor(k*minor/major) increments.
  task automatic expect_move(input int x, input int y);
    int ax, ay, mj, mn;
    bit xm, hit;
    ax = iabs(x);
    ay = iabs(y);
    xm = (ax >= ay);
    mj = xm ? ax : ay;
    mn = xm ? ay : ax;
    for (int k = 1; k <= mj; k++) begin
      hit = ((k * mn) / mj) != (((k - 1) * mn) / mj);
      pulse_q.push_back({xm ? 1'b1 : hit, xm ? hit : 1'b1, (x >= 0), (y >= 0)});
    end
    dur_q.push_back(2 + mj * (PH + PL));
  endtask

  task automatic start_move(input int x, input int y, input bit hold);
    int n;
    n = 0;
    cnt_x = 0;
    cnt_y = 0;
    expect_move(x, y);
    x_steps = SW'(x);
    y_steps = SW'(y);
    trigger = 1'b1;
    while (rdy && n < 100) begin
      step_clk();
      n++;
    end
    if (rdy) chk("accept_timeout", 0, 1);
    if (!hold) trigger = 1'b0;
  endtask

  task automatic wait_move(input int limit);
    int n;
    bit scr;
    n = 0;
    scr = 1'b0;
    while (!rdy && n < limit) begin
      step_clk();
      n++;
      if (!scr && (step_x || step_y || done)) begin
        x_steps = SW'($urandom);
        y_steps = SW'($urandom);
        scr = 1'b1;
      end
    end
    if (!rdy) chk("move_timeout", 0, 1);
  endtask

  task automatic run_move(input int x, input int y);
    int mx;
    mx = (iabs(x) > iabs(y)) ? iabs(x) : iabs(y);
    start_move(x, y, 1'b0);
    wait_move((mx + 2) * (PH + PL) * 8 + 100);
    chk("pulses_x", cnt_x, iabs(x));
    chk("pulses_y", cnt_y, iabs(y));
    chk("queue_drained", pulse_q.size(), 0);
  endtask

  initial begin
    int n;
    // Reset with clk_en low
    repeat (3) @(posedge clk);
    #1;
    chk("rst_step_x", int'(step_x), 0);
    chk("rst_step_y", int'(step_y), 0);
    chk("rst_dir_x", int'(dir_x), 1);
    chk("rst_dir_y", int'(dir_y), 1);
    chk("rst_rdy", int'(rdy), 1);
    chk("rst_done", int'(done), 1);
    reset = 1'b1;
    clk_en = 1'b1;
    step_clk();

    run_move(4, 2);
    run_move(-3, 3);
    run_move(0, 0);
    run_move(-128, 1);
    run_move(1, -127);

    en_rand = 1'b1;
    for (int i = 0; i < 25; i++) begin
      run_move(int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20);
      repeat ($urandom_range(0, 3)) step_clk();
    end
    en_rand = 1'b0;
    step_clk();

    // Trigger held across the move, clk_en frozen during the first high phase
    start_move(3, 1, 1'b1);
    n = 0;
    while (!step_x && n < 100) begin
      step_clk();
      n++;
    end
    chk("freeze_reached", int'(step_x), 1);
    clk_en = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("freeze_step_x", int'(step_x), 1);
      chk("freeze_step_y", int'(step_y), 0);
      chk("freeze_rdy", int'(rdy), 0);
      chk("freeze_done", int'(done), 0);
    end
    clk_en = 1'b1;
    n = 0;
    while (!(done && !rdy) && n < 200) begin
      step_clk();
      n++;
    end
    chk("hold_done_tick", int'(done && !rdy), 1);
    trigger = 1'b0;
    repeat (4) begin
      step_clk();
      chk("hold_no_restart", int'(rdy), 1);
    end
    chk("hold_pulses_x", cnt_x, 3);
    chk("hold_pulses_y", cnt_y, 1);

    // Reset during the second pulse
    start_move(5, 0, 1'b0);
    n = 0;
    while (cnt_x < 2 && n < 200) begin
      step_clk();
      n++;
    end
    chk("rst_mid_reached", cnt_x, 2);
    aborted = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_mid_step_x", int'(step_x), 0);
    chk("rst_mid_rdy", int'(rdy), 1);
    chk("rst_mid_done", int'(done), 1);
    pulse_q.delete();
    dur_q.delete();
    repeat (10) begin
      step_clk();
      chk("rst_mid_idle", int'(rdy && done), 1);
    end
    chk("rst_mid_pulses", cnt_x, 2);

`ifdef MOTORS_STEP_CTRL_ABORT_EN
    start_move(5, 0, 1'b0);
    n = 0;
    while (cnt_x < 2 && n < 200) begin
      step_clk();
      n++;
    end
    aborted = 1'b1;
    abort = 1'b1;
    #1;
    chk("abort_step_forced", int'(step_x), 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_done_tick", int'({done, rdy}), 2);
    step_clk();
    chk("abort_idle", int'(rdy), 1);
    chk("abort_pulses", cnt_x, 2);
    pulse_q.delete();
    dur_q.delete();
`endif

    run_move(2, -7);
    repeat (5) step_clk();
    chk("final_moves_drained", dur_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
